// File: rtl/mem_acc_pkg.sv
// Shared encodings for the data-RAM access controller: FSM states, access sizes, latched request.
package mem_acc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } req_t;

    // The reserved size code 11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane logic: extracts/extends load data and merges sub-word store data into a word.
// Purely combinational; sizes other than byte/half pass the word straight through.
module byte_lane_merge
    import mem_acc_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b      = rd_word[{addr_lo, 3'b000} +: 8];
        lane_h      = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data   = rd_word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{~uns & lane_b[7]}}, lane_b};
                merged_word = rd_word;
                merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data   = {{16{~uns & lane_h[15]}}, lane_h};
                merged_word = addr_lo[1] ? {wdata[15:0], rd_word[15:0]}
                                         : {rd_word[31:16], wdata[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-RAM initiator: load/store sequencing with sub-word RMW; MISALIGN_TRAP_EN enables misalignment traps.
// Response 2 cycles after accept (3 for sub-word store, 1 for trap); req_ready only in IDLE, no resp backpressure.
module mem_access_ctrl
    import mem_acc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DataWidth-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [AddrWidth-1:0] ram_addr,
    output logic                 ram_r,
    output logic                 ram_w,
    output logic [DataWidth-1:0] ram_wdata,
    input  logic [DataWidth-1:0] ram_rdata
);

    logic [1:0]  state;
    req_t        req_q;
    logic        trap;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    assign trap = misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (req_valid && req_ready) begin
            err_q <= trap;
        end
    end

    assign resp_err = err_q && resp_valid;
`else
    assign trap     = 1'b0;
    assign resp_err = 1'b0;
`endif

    byte_lane_merge u_lane (
        .size        (req_q.size),
        .addr_lo     (req_q.addr_lo),
        .uns         (req_q.uns),
        .rd_word     (ram_rdata),
        .wdata       (req_q.wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // ram_addr only moves on accept, so it is stable across every RD/WR strobe of an access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            resp_rdata <= '0;
            ram_addr   <= '0;
            ram_r      <= 1'b0;
            ram_w      <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{we: req_we, size: req_size, uns: req_unsigned,
                                   addr_lo: req_addr[1:0], wdata: req_wdata};
                        if (trap) begin
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            ram_addr <= {req_addr[AddrWidth-1:2], 2'b00};
                            if (req_we && is_word(req_size)) begin
                                ram_w     <= 1'b1;
                                ram_wdata <= req_wdata;
                                state     <= ST_WR;
                            end else begin
                                ram_r <= 1'b1;
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    ram_r <= 1'b0;
                    if (req_q.we) begin
                        ram_w     <= 1'b1;
                        ram_wdata <= merged_word;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= load_data;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    ram_w      <= 1'b0;
                    resp_rdata <= '0;
                    state      <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word-array RAM model, shadow memory reference, per-cycle response checker.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic        ram_r;
    logic        ram_w;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] ram [0:255] = '{default: 32'h0};
    logic [31:0] mdl [0:255];

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int rsp_cnt  = 0;

    int          e_lat, e_nw, e_nr;
    logic [31:0] e_rdata, e_addr, e_wword;
    logic        e_err;
    logic [31:0] got_rdata;
    logic        got_err;

    mem_access_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_r        (ram_r),
        .ram_w        (ram_w),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 CLK = ~CLK;

    assign ram_rdata = ram[ram_addr[9:2]];
    always @(posedge CLK) if (ram_w) ram[ram_addr[9:2]] <= ram_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        v = w;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh   = 0;
        mask = 32'hFFFF_FFFF;
        if (sz == 2'b00) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else if (sz == 2'b01) begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // Runs for the whole sim: every cycle between accept and response is checked against the model.
    task automatic compare_loop();
        int cyc = 0;
        int nw  = 0;
        int nr  = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                cyc = 0; nw = 0; nr = 0;
            end else if (rsp_cnt != acc_cnt) begin
                cyc++;
                if (ram_w) begin
                    nw++;
                    chk("wr_addr", ram_addr, e_addr);
                    chk("wr_data", ram_wdata, e_wword);
                end
                if (ram_r) begin
                    nr++;
                    chk("rd_addr", ram_addr, e_addr);
                end
                chk("ready_busy", {31'b0, req_ready}, 32'd0);
                if (cyc >= e_lat) begin
                    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
                    chk("resp_rdata", resp_rdata, e_rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
                    chk("ram_w_cycles", nw, e_nw);
                    chk("ram_r_cycles", nr, e_nr);
                    got_rdata = resp_rdata;
                    got_err   = resp_err;
                    cyc = 0; nw = 0; nr = 0;
                    rsp_cnt++;
                end else begin
                    chk("resp_early", {31'b0, resp_valid}, 32'd0);
                end
            end else begin
                chk("resp_idle", {31'b0, resp_valid}, 32'd0);
            end
        end
    endtask

    task automatic op(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] lit, input logic lit_err);
        int          n;
        logic        mis;
        logic [31:0] w;
        @(negedge CLK);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge CLK);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
        w       = mdl[a[9:2]];
        e_addr  = {a[31:2], 2'b00};
        e_err   = mis;
        e_lat   = mis ? 1 : ((we && !sz[1]) ? 3 : 2);
        e_nw    = (!mis && we) ? 1 : 0;
        e_nr    = (!mis && (!we || !sz[1])) ? 1 : 0;
        e_rdata = (mis || we) ? 32'h0 : mdl_load(w, sz, u, a);
        e_wword = mdl_store(w, sz, a, wd);
        if (we && !mis) mdl[a[9:2]] = e_wword;
        acc_cnt++;
        #1 req_valid = 1'b0;
        n = 0;
        while (rsp_cnt != acc_cnt && n < 20) begin
            @(posedge CLK);
            n++;
        end
        if (rsp_cnt != acc_cnt) begin
            chk("resp_timeout", 32'd0, 32'd1);
            rsp_cnt = acc_cnt;
        end else begin
            chk("lit_rdata", got_rdata, lit);
            chk("lit_err", {31'b0, got_err}, {31'b0, lit_err});
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
        fork
            compare_loop();
        join_none

        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_ram_r", {31'b0, ram_r}, 32'd0);
        chk("rst_ram_w", {31'b0, ram_w}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        RST = 1'b0;

        //  we    size   uns   addr       wdata          literal rdata  err
        op(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h1234_5678, 1'b0);
        op(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AB, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h1234_AB78, 1'b0);
        op(1'b0, 2'b00, 1'b0, 32'h41, 32'h0,         32'hFFFF_FFAB, 1'b0);
        op(1'b0, 2'b00, 1'b1, 32'h41, 32'h0,         32'h0000_00AB, 1'b0);
        op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0,         32'h0000_1234, 1'b0);
        op(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'hBEEF_AB78, 1'b0);
        op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0,         32'hFFFF_BEEF, 1'b0);
        op(1'b0, 2'b01, 1'b1, 32'h42, 32'h0,         32'h0000_BEEF, 1'b0);
        op(1'b0, 2'b00, 1'b0, 32'h43, 32'h0,         32'hFFFF_FFBE, 1'b0);
        op(1'b0, 2'b00, 1'b0, 32'h40, 32'h0,         32'h0000_0078, 1'b0);
        op(1'b0, 2'b01, 1'b0, 32'h40, 32'h0,         32'hFFFF_AB78, 1'b0);
        op(1'b1, 2'b11, 1'b0, 32'h80, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,         32'hCAFE_F00D, 1'b0);
`ifdef MISALIGN_TRAP_EN
        op(1'b0, 2'b10, 1'b0, 32'h41, 32'h0,         32'h0000_0000, 1'b1);
        op(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_1234, 32'h0000_0000, 1'b1);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'hBEEF_AB78, 1'b0);
`else
        op(1'b0, 2'b10, 1'b0, 32'h41, 32'h0,         32'hBEEF_AB78, 1'b0);
        op(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_1234, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h1234_AB78, 1'b0);
`endif

        // Reset asserted while the sub-word store is in its write cycle: nothing may land in RAM.
        @(negedge CLK);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h43; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        n = 0;
        while (!ram_w && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("rmw_reached_wr", {31'b0, ram_w}, 32'd1);
        RST = 1'b1;
        #1;
        chk("arst_ram_w", {31'b0, ram_w}, 32'd0);
        chk("arst_ram_r", {31'b0, ram_r}, 32'd0);
        chk("arst_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

`ifdef MISALIGN_TRAP_EN
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'hBEEF_AB78, 1'b0);
`else
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h1234_AB78, 1'b0);
`endif
        op(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_0011, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b00, 1'b1, 32'h40, 32'h0,         32'h0000_0011, 1'b0);

        chk("ram_word_40", ram[16], mdl[16]);
        chk("ram_word_80", ram[32], mdl[32]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
